// File: rtl/stream_demux_spill_if.sv
// ---------------------------------------------------------------------------
// stream_demux_spill_if
//   Handshake bundle for stream_demux_spill: one shared input stream carrying
//   {data, sel}, fanned out to N_OUP valid/ready output streams plus a drop
//   strobe for transactions whose select is out of range.
//
//   Signals (named from the demux's point of view):
//     inp_data_i   payload of the input stream
//     inp_sel_i    destination index, travels with inp_data_i
//     inp_valid_i  input valid
//     inp_ready_o  input ready (registered inside the demux)
//     oup_data_o   head payload, replicated on every output
//     oup_valid_o  per-output valid, at most one bit set
//     oup_ready_i  per-output ready
//     drop_o       pulse when an out-of-range transaction is discarded
//
//   Modports:
//     slave   the demux itself
//     master  the environment: upstream producer plus downstream consumers
// ---------------------------------------------------------------------------
interface stream_demux_spill_if #(
  parameter type         DATA_T = logic,
  parameter int unsigned N_OUP  = 3
);
  localparam int unsigned LOG_N_OUP = $clog2(N_OUP);

  DATA_T                  inp_data_i;
  logic [LOG_N_OUP-1:0]   inp_sel_i;
  logic                   inp_valid_i;
  logic                   inp_ready_o;
  DATA_T [N_OUP-1:0]      oup_data_o;
  logic  [N_OUP-1:0]      oup_valid_o;
  logic  [N_OUP-1:0]      oup_ready_i;
  logic                   drop_o;

  modport slave (
    input  inp_data_i,
    input  inp_sel_i,
    input  inp_valid_i,
    output inp_ready_o,
    output oup_data_o,
    output oup_valid_o,
    input  oup_ready_i,
    output drop_o
  );

  modport master (
    output inp_data_i,
    output inp_sel_i,
    output inp_valid_i,
    input  inp_ready_o,
    input  oup_data_o,
    input  oup_valid_o,
    output oup_ready_i,
    input  drop_o
  );

endinterface

// File: rtl/stream_demux_spill.sv
// ---------------------------------------------------------------------------
// stream_demux_spill
//   Registered 1-to-N_OUP stream demultiplexer. Each input transaction
//   carries its destination index; it is stored in a two-slot spill buffer
//   and presented on the selected output. Both handshake directions are
//   fully registered: inp_ready_o depends only on buffer occupancy and
//   oup_valid_o depends only on the head slot, so no combinational path
//   runs from input to output or from oup_ready_i back to inp_ready_o.
//   Delivery is strict FIFO across all outputs (head-of-line blocking).
//   A transaction whose select is >= N_OUP is discarded at the head with a
//   one-cycle drop_o pulse and is never presented on any output.
//
//   Ports:
//     clk_i    clock, rising edge
//     rst_ni   asynchronous active-low reset
//     clear_i  synchronous flush of both slots (wins over any transfer)
//     bus      stream_demux_spill_if.slave handshake bundle
// ---------------------------------------------------------------------------
module stream_demux_spill #(
  parameter type         DATA_T = logic,
  parameter int unsigned N_OUP  = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  stream_demux_spill_if.slave       bus
);

  localparam int unsigned LOG_N_OUP = $clog2(N_OUP);

  typedef logic [LOG_N_OUP-1:0] sel_t;

  // EMPTY: no slot full; ONE: head (A) full; FULL: head and spill (B) full.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  DATA_T  a_data_q, a_data_d;
  DATA_T  b_data_q, b_data_d;
  sel_t   a_sel_q,  a_sel_d;
  sel_t   b_sel_q,  b_sel_d;

  logic             a_full;
  logic             b_full;
  logic             a_oob;
  logic             head_ready;
  logic             push;
  logic             pop;
  logic [N_OUP-1:0] oup_valid;
  DATA_T [N_OUP-1:0] oup_data;

  // -------------------------------------------------------------------------
  // Occupancy flags and handshake decode
  // -------------------------------------------------------------------------
  assign a_full = (state_q != EMPTY);
  assign b_full = (state_q == FULL);

  // Select values beyond the last output are legal on the wire but have no
  // consumer; they are retired from the head unconditionally.
  assign a_oob = (32'(a_sel_q) >= N_OUP);

  // Ready of the destination currently addressed by the head; decoded with
  // an explicit compare so an out-of-range select never indexes past the
  // ready vector.
  always_comb begin
    head_ready = 1'b0;
    for (int unsigned i = 0; i < N_OUP; i++) begin
      if (32'(a_sel_q) == i) begin
        head_ready = bus.oup_ready_i[i];
      end
    end
  end

  assign push = bus.inp_valid_i && !b_full;
  assign pop  = a_full && (a_oob || head_ready);

  // -------------------------------------------------------------------------
  // Output drive: valid is a pure function of the head slot
  // -------------------------------------------------------------------------
  always_comb begin
    oup_valid = '0;
    oup_data  = '0;
    for (int unsigned i = 0; i < N_OUP; i++) begin
      oup_valid[i] = a_full && (32'(a_sel_q) == i);
      oup_data[i]  = a_data_q;
    end
  end

  assign bus.inp_ready_o = !b_full;
  assign bus.oup_valid_o = oup_valid;
  assign bus.oup_data_o  = oup_data;
  assign bus.drop_o      = a_full && a_oob;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    a_data_d = a_data_q;
    a_sel_d  = a_sel_q;
    b_data_d = b_data_q;
    b_sel_d  = b_sel_q;

    unique case (state_q)
      EMPTY: begin
        if (push) begin
          a_data_d = bus.inp_data_i;
          a_sel_d  = bus.inp_sel_i;
          state_d  = ONE;
        end
      end

      ONE: begin
        if (push && pop) begin
          // Head leaves and the new item takes its place in the same cycle.
          a_data_d = bus.inp_data_i;
          a_sel_d  = bus.inp_sel_i;
        end else if (push) begin
          b_data_d = bus.inp_data_i;
          b_sel_d  = bus.inp_sel_i;
          state_d  = FULL;
        end else if (pop) begin
          state_d  = EMPTY;
        end
      end

      FULL: begin
        // inp_ready_o is low here, so only a pop can happen.
        if (pop) begin
          a_data_d = b_data_q;
          a_sel_d  = b_sel_q;
          state_d  = ONE;
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flush discards both slots; any handshake completing alongside it has
    // already been honoured on the wires and is simply not retained.
    if (clear_i) begin
      state_d = EMPTY;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= EMPTY;
      a_data_q <= '0;
      a_sel_q  <= '0;
      b_data_q <= '0;
      b_sel_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_data_q <= a_data_d;
      a_sel_q  <= a_sel_d;
      b_data_q <= b_data_d;
      b_sel_q  <= b_sel_d;
    end
  end

endmodule

// File: tb/tb_stream_demux_spill.sv
module tb_stream_demux_spill;

  localparam int unsigned N = 3;
  typedef logic [7:0] data_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  stream_demux_spill_if #(.DATA_T(data_t), .N_OUP(N)) bus ();

  stream_demux_spill #(.DATA_T(data_t), .N_OUP(N)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .bus     (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s);
    bus.inp_valid_i = v;
    bus.inp_data_i  = d;
    bus.inp_sel_i   = s;
  endtask

  // Scoreboard state for the randomized phase
  data_t       qd[$];
  logic [1:0]  qs[$];
  logic        pend   = 1'b0;
  logic        pstall = 1'b0;
  logic [2:0]  pv     = '0;
  data_t       pdat   = '0;
  int unsigned n_in   = 0;

  task automatic rnd_cycle(input logic allow_new, input logic [2:0] rdy);
    if (allow_new && !pend && ($urandom_range(0, 3) != 0)) begin
      pend = 1'b1;
      bus.inp_data_i = 8'($urandom);
      bus.inp_sel_i  = 2'($urandom_range(0, 3));
    end
    bus.inp_valid_i = pend;
    bus.oup_ready_i = rdy;
    #1;
    if (pstall) begin
      chk("rnd_hold_valid", 32'(bus.oup_valid_o), 32'(pv));
      chk("rnd_hold_data", 32'(bus.oup_data_o[0]), 32'(pdat));
    end
    if (|bus.oup_valid_o)
      chk("rnd_onehot", 32'($countones(bus.oup_valid_o)), 1);
    if (bus.drop_o) begin
      if (qs.size() == 0) chk("rnd_spurious_drop", 1, 0);
      else begin
        chk("rnd_drop_sel", 32'(qs[0]), 3);
        chk("rnd_drop_valid", 32'(bus.oup_valid_o), 0);
        void'(qs.pop_front());
        void'(qd.pop_front());
      end
    end else if (|(bus.oup_valid_o & bus.oup_ready_i)) begin
      if (qs.size() == 0) chk("rnd_spurious_out", 1, 0);
      else begin
        chk("rnd_out_valid", 32'(bus.oup_valid_o), 32'(1 << qs[0]));
        chk("rnd_out_data", 32'(bus.oup_data_o[0]), 32'(qd[0]));
        void'(qs.pop_front());
        void'(qd.pop_front());
      end
    end
    pstall = |(bus.oup_valid_o & ~bus.oup_ready_i);
    pv     = bus.oup_valid_o;
    pdat   = bus.oup_data_o[0];
    if (pend && bus.inp_ready_o) begin
      qd.push_back(bus.inp_data_i);
      qs.push_back(bus.inp_sel_i);
      pend = 1'b0;
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 8'h00, 2'd0);
    bus.oup_ready_i = '0;

    // ---------------- reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus.oup_valid_o), 0);
    chk("reset_ready", 32'(bus.inp_ready_o), 1);
    chk("reset_drop", 32'(bus.drop_o), 0);
    chk("reset_data", 32'(bus.oup_data_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---------------- streaming, all outputs ready
    bus.oup_ready_i = 3'b111;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'(8'h10 + k), 2'(k % 3));
      chk("t1_inready", 32'(bus.inp_ready_o), 1);
      step();
      chk("t1_valid", 32'(bus.oup_valid_o), 32'(1 << (k % 3)));
      chk("t1_data", 32'(bus.oup_data_o[k % 3]), 32'(16 + k));
    end
    drive(1'b0, 8'h00, 2'd0);
    step();
    chk("t1_idle", 32'(bus.oup_valid_o), 0);

    // ---------------- backpressure on output 1
    bus.oup_ready_i = 3'b101;
    drive(1'b1, 8'h11, 2'd1);
    step();
    chk("t2_valid_first", 32'(bus.oup_valid_o), 32'h2);
    chk("t2_ready_first", 32'(bus.inp_ready_o), 1);
    drive(1'b1, 8'h22, 2'd0);
    step();
    drive(1'b0, 8'h00, 2'd0);
    chk("t2_ready_full", 32'(bus.inp_ready_o), 0);
    chk("t2_valid_full", 32'(bus.oup_valid_o), 32'h2);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_hold_valid", 32'(bus.oup_valid_o), 32'h2);
      chk("t2_hold_data", 32'(bus.oup_data_o[1]), 32'h11);
      chk("t2_hold_ready", 32'(bus.inp_ready_o), 0);
    end
    bus.oup_ready_i = 3'b111;
    step();
    chk("t2_second_valid", 32'(bus.oup_valid_o), 32'h1);
    chk("t2_second_data", 32'(bus.oup_data_o[0]), 32'h22);
    chk("t2_ready_back", 32'(bus.inp_ready_o), 1);
    step();
    chk("t2_idle", 32'(bus.oup_valid_o), 0);

    // ---------------- clear while full
    bus.oup_ready_i = 3'b000;
    drive(1'b1, 8'h33, 2'd2);
    step();
    drive(1'b1, 8'h44, 2'd0);
    step();
    drive(1'b0, 8'h00, 2'd0);
    chk("t3_full", 32'(bus.inp_ready_o), 0);
    chk("t3_head", 32'(bus.oup_valid_o), 32'h4);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t3_clr_valid", 32'(bus.oup_valid_o), 0);
    chk("t3_clr_ready", 32'(bus.inp_ready_o), 1);
    bus.oup_ready_i = 3'b111;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_no_ghost", 32'(bus.oup_valid_o), 0);
    end
    // push accepted in the clear cycle is discarded
    drive(1'b1, 8'h55, 2'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b0, 8'h00, 2'd0);
    chk("t3_clr_push", 32'(bus.oup_valid_o), 0);

    // ---------------- out-of-range select is dropped
    drive(1'b1, 8'hA5, 2'd3);
    step();
    chk("t4_drop", 32'(bus.drop_o), 1);
    chk("t4_drop_valid", 32'(bus.oup_valid_o), 0);
    drive(1'b1, 8'h5A, 2'd2);
    step();
    drive(1'b0, 8'h00, 2'd0);
    chk("t4_drop_end", 32'(bus.drop_o), 0);
    chk("t4_next_valid", 32'(bus.oup_valid_o), 32'h4);
    chk("t4_next_data", 32'(bus.oup_data_o[2]), 32'h5A);
    step();
    chk("t4_idle_valid", 32'(bus.oup_valid_o), 0);
    chk("t4_idle_drop", 32'(bus.drop_o), 0);

    // ---------------- randomized traffic with scoreboard
    for (int c = 0; c < 4000; c++) rnd_cycle(1'b1, 3'($urandom));
    for (int c = 0; c < 12; c++) rnd_cycle(1'b0, 3'b111);
    chk("rnd_drained", 32'(qd.size()), 0);
    chk("rnd_no_pending", 32'(pend), 0);
    chk("rnd_traffic", 32'(n_in > 1000), 1);
    drive(1'b0, 8'h00, 2'd0);

    // ---------------- asynchronous reset while full
    bus.oup_ready_i = 3'b000;
    drive(1'b1, 8'h61, 2'd0);
    step();
    drive(1'b1, 8'h62, 2'd1);
    step();
    drive(1'b0, 8'h00, 2'd0);
    chk("t6_full", 32'(bus.inp_ready_o), 0);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", 32'(bus.oup_valid_o), 0);
    chk("t6_rst_ready", 32'(bus.inp_ready_o), 1);
    chk("t6_rst_drop", 32'(bus.drop_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_after_rst", 32'(bus.oup_valid_o), 0);
    bus.oup_ready_i = 3'b111;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'(8'h71 + k), 2'(2 - k));
      step();
      chk("t6_valid", 32'(bus.oup_valid_o), 32'(1 << (2 - k)));
      chk("t6_data", 32'(bus.oup_data_o[2 - k]), 32'(8'h71 + k));
    end
    drive(1'b0, 8'h00, 2'd0);
    step();
    chk("t6_idle", 32'(bus.oup_valid_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
